// File: rtl/mc_cpu_pkg.sv
// Shared types for the multi-cycle 16-bit-instruction core.
// Opcodes, branch conditions, FSM states, flag indices, field helpers.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_ADDI = 4'h3,
    OP_AND  = 4'h4,
    OP_ORR  = 4'h5,
    OP_XOR  = 4'h6,
    OP_LSL  = 4'h7,
    OP_LSR  = 4'h8,
    OP_MOVI = 4'h9,
    OP_LDR  = 4'hA,
    OP_STR  = 4'hB,
    OP_BCC  = 4'hC,
    OP_BL   = 4'hD,
    OP_BX   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    C_EQ = 4'h0,
    C_NE = 4'h1,
    C_LT = 4'h2,
    C_GE = 4'h3,
    C_AL = 4'h4
  } cond_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RA_LSB = 4;
  localparam int RB_LSB = 0;

  function automatic logic [3:0] fld(
    input logic [15:0] i,
    input int          lsb
  );
    return i[lsb +: 4];
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational ALU: add/sub/logic/shift on DATA_W operands.
// Ports: a, b, op in; result and nzcv out.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        nzcv
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [4:0]      sh;
  logic            c;
  logic            v;

  assign sh = b[4:0];

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[M:0];
        c      = sum[DATA_W];
        v      = (a[M] == b[M]) && (result[M] != a[M]);
      end
      OP_SUB: begin
        // carry out of a + ~b + 1 is the "no borrow" flag
        sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        result = sum[M:0];
        c      = sum[DATA_W];
        v      = (a[M] != b[M]) && (result[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_XOR: result = a ^ b;
      OP_LSL: result = (int'(sh) >= DATA_W) ? '0 : a << sh;
      OP_LSR: result = (int'(sh) >= DATA_W) ? '0 : a >> sh;
      default: result = '0;
    endcase
  end

  assign nzcv = {result[M], result == '0, c, v};

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/HALT over one shared mem port.
// Ports: clk, reset(n), mem req/ack bus, retire, halted, dbg_pc.
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] pc, addr_q;
  logic [15:0]       instr;
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] va, vb, vd;
  logic [3:0]        flags;
  logic              req;

  opcode_e    op;
  logic [3:0] rd, ra, rb;

  assign op = opcode_e'(fld(instr, OP_LSB));
  assign rd = fld(instr, RD_LSB);
  assign ra = fld(instr, RA_LSB);
  assign rb = fld(instr, RB_LSB);

  logic [DATA_W-1:0] alu_b, alu_res;
  logic [3:0]        alu_nzcv;
  opcode_e           alu_op;

  assign alu_b  = (op == OP_ADDI) ? DATA_W'(rb) : vb;
  assign alu_op = (op == OP_ADDI) ? OP_ADD : op;

  mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (va),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .nzcv   (alu_nzcv)
  );

  logic [ADDR_W-1:0] pc_inc, br_off, bl_off, ls_addr;
  logic              taken;

  assign pc_inc  = pc + ADDR_W'(1);
  assign br_off  = ADDR_W'($signed(instr[7:0]));
  assign bl_off  = ADDR_W'($signed(instr[11:0]));
  assign ls_addr = ADDR_W'(va + DATA_W'(rb));

  always_comb begin
    taken = 1'b0;
    case (rd)
      C_EQ: taken = flags[FLAG_Z];
      C_NE: taken = !flags[FLAG_Z];
      C_LT: taken = flags[FLAG_N] != flags[FLAG_V];
      C_GE: taken = flags[FLAG_N] == flags[FLAG_V];
      C_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (op == OP_LDR || op == OP_STR) begin
          state_nx = S_MEM;
        end else begin
          retire   = 1'b1;
          state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
        end
      end
      S_MEM: begin
        req      = 1'b1;
        mem_we   = (op == OP_STR);
        mem_addr = addr_q;
        if (mem_ack) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // reset parks the FSM in FETCH; gate so no request leaks out meanwhile
  assign mem_req   = req & reset;
  assign mem_wdata = vd;
  assign halted    = (state == S_HALT);
  assign dbg_pc    = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      flags  <= '0;
      instr  <= '0;
      addr_q <= '0;
      va     <= '0;
      vb     <= '0;
      vd     <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (mem_ack) instr <= mem_rdata[15:0];
        S_DECODE: begin
          va <= rf[ra];
          vb <= rf[rb];
          vd <= rf[rd];
        end
        S_EXEC: begin
          pc <= pc_inc;
          case (op)
            OP_ADD, OP_SUB, OP_ADDI: begin
              rf[rd] <= alu_res;
              flags  <= alu_nzcv;
            end
            OP_AND, OP_ORR, OP_XOR: begin
              rf[rd]        <= alu_res;
              flags[FLAG_N] <= alu_nzcv[FLAG_N];
              flags[FLAG_Z] <= alu_nzcv[FLAG_Z];
            end
            OP_LSL, OP_LSR: rf[rd] <= alu_res;
            OP_MOVI: rf[rd] <= DATA_W'(instr[7:0]);
            OP_LDR, OP_STR: begin
              addr_q <= ls_addr;
              pc     <= pc;
            end
            OP_BCC: if (taken) pc <= pc_inc + br_off;
            OP_BL: begin
              rf[14] <= DATA_W'(pc_inc);
              pc     <= pc_inc + bl_off;
            end
            OP_BX: pc <= va[ADDR_W-1:0];
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == OP_LDR) rf[rd] <= mem_rdata;
            pc <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // carry is architecturally visible but no branch condition reads it
  logic unused;
  assign unused = flags[FLAG_C];

endmodule

// File: tb/tb_mc_cpu_core.sv
// Scoreboard bench for mc_cpu_core: expected bus transactions and
// retire cycles are queued; a monitor pops and compares them.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        retire, halted;
  logic [15:0] dbg_pc;

  always #5 clk = ~clk;

  mc_cpu_core #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .retire    (retire),
    .halted    (halted),
    .dbg_pc    (dbg_pc)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
  } txn_t;

  txn_t        exp_q[$];
  int          exp_ret[$];
  logic [15:0] mem [256];
  int          n_chk = 0;
  int          n_fail = 0;
  int          delay = 0;
  bit          manual = 1'b0;
  time         t_rel = 0;
  int          ret_cnt = 0;

  function automatic int cyc();
    return int'(($time - t_rel) / 10) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // memory model: ack after 'delay' waiting cycles, driven at negedge
  initial begin : model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (!reset) begin
          mem_ack = 1'b0;
          cnt = 0;
        end else begin
          if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
          end
          if (mem_req) begin
            if (cnt >= delay) begin
              mem_ack = 1'b1;
              mem_rdata = mem[mem_addr[7:0]];
              if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
            end else begin
              cnt++;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    bit          in_txn, unstable;
    logic        we0;
    logic [15:0] a0, d0;
    int          len;
    txn_t        e;
    in_txn = 0; unstable = 0; we0 = 0; a0 = 0; d0 = 0; len = 0;
    forever begin
      @(negedge clk);
      #3;
      if (reset && retire) begin
        ret_cnt++;
        if (exp_ret.size() > 0)
          chk("retire_cycle", cyc(), exp_ret.pop_front());
      end
      if (reset && mem_req) begin
        if (!in_txn) begin
          in_txn = 1; we0 = mem_we; a0 = mem_addr;
          d0 = mem_wdata; len = 0; unstable = 0;
        end else if (mem_we !== we0 || mem_addr !== a0 ||
                     (we0 && mem_wdata !== d0)) begin
          unstable = 1;
        end
        len++;
        if (mem_ack) begin
          in_txn = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_extra: got addr 0x%0h we %0b, none queued",
                     a0, we0);
          end else begin
            e = exp_q.pop_front();
            chk("txn_we", 32'(we0), 32'(e.we));
            chk("txn_addr", 32'(a0), 32'(e.addr));
            if (e.we) chk("txn_wdata", 32'(d0), 32'(e.wdata));
            chk("txn_len", len, e.len);
            chk("txn_stable", 32'(unstable), 0);
          end
        end
      end else begin
        in_txn = 0;
      end
    end
  end

  task automatic pf(input logic [15:0] a);
    txn_t t;
    t = '{1'b0, a, 16'h0, delay + 1};
    exp_q.push_back(t);
  endtask

  task automatic ps(input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t = '{1'b1, a, d, delay + 1};
    exp_q.push_back(t);
  endtask

  task automatic pl(input logic [15:0] a);
    txn_t t;
    t = '{1'b0, a, 16'h0, delay + 1};
    exp_q.push_back(t);
  endtask

  task automatic clr_mem();
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 reset = 1'b1;
    t_rel = $time;
  endtask

  task automatic wait_halt(input int maxc, output int hc);
    hc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #3;
      if (halted) begin
        hc = cyc();
        break;
      end
    end
    if (hc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL halt_timeout: no halt within %0d cycles", maxc);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic load_p1();
    clr_mem();
    mem[0] = 16'h9105;
    mem[1] = 16'h9203;
    mem[2] = 16'h2312;
    mem[3] = 16'hF000;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin : main
    int hc, base;
    logic [15:0] acc;
    hc = 0; base = 0; acc = '0;

    @(negedge clk);
    #3;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_dbg_pc", 32'(dbg_pc), 0);

    // MOVI/MOVI/SUB/HALT, zero-wait
    delay = 0;
    load_p1();
    pf(0); pf(1); pf(2); pf(3);
    exp_ret.push_back(3); exp_ret.push_back(6);
    exp_ret.push_back(9); exp_ret.push_back(12);
    base = ret_cnt;
    release_rst();
    wait_halt(40, hc);
    chk("p1_halt_cycle", hc, 13);
    chk("p1_r3", 32'(dut.rf[3]), 32'h2);
    chk("p1_nzcv", 32'(dut.flags), 32'b0010);
    chk("p1_retires", ret_cnt - base, 4);

    // ack while no request is outstanding
    manual = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("glitch_halted", 32'(halted), 1);
    chk("glitch_req", 32'(mem_req), 0);
    chk("glitch_retires", ret_cnt - base, 4);
    mem_ack = 1'b0;
    manual = 1'b0;

    // ADD 0x7FFF + 1 then BGE taken (N=V=1)
    do_reset();
    clr_mem();
    mem[0] = 16'h91FF; mem[1] = 16'h927F; mem[2] = 16'h9408;
    mem[3] = 16'h7224; mem[4] = 16'h5221; mem[5] = 16'h9501;
    mem[6] = 16'h1625; mem[7] = 16'h9740; mem[8] = 16'hB670;
    mem[9] = 16'hC301; mem[10] = 16'hF000; mem[11] = 16'hF000;
    for (int i = 0; i <= 8; i++) pf(16'(i));
    ps(16'h40, 16'h8000);
    pf(9); pf(11);
    base = ret_cnt;
    release_rst();
    wait_halt(200, hc);
    chk("add_r2", 32'(dut.rf[2]), 32'h7FFF);
    chk("add_r6", 32'(dut.rf[6]), 32'h8000);
    chk("add_nzcv", 32'(dut.flags), 32'b1001);
    chk("add_mem40", 32'(mem[8'h40]), 32'h8000);
    chk("add_retires", ret_cnt - base, 11);

    // SUB 0 - 1 then BLT taken (N=1, V=0)
    do_reset();
    clr_mem();
    mem[0] = 16'h9501; mem[1] = 16'h2805; mem[2] = 16'h9740;
    mem[3] = 16'hB871; mem[4] = 16'hC201; mem[5] = 16'hF000;
    mem[6] = 16'hF000;
    pf(0); pf(1); pf(2); pf(3);
    ps(16'h41, 16'hFFFF);
    pf(4); pf(6);
    base = ret_cnt;
    release_rst();
    wait_halt(100, hc);
    chk("sub_r8", 32'(dut.rf[8]), 32'hFFFF);
    chk("sub_nzcv", 32'(dut.flags), 32'b1000);
    chk("sub_retires", ret_cnt - base, 6);

    // BEQ taken, BL forward/back, BX, LSR incl. shift >= width
    do_reset();
    clr_mem();
    mem[0] = 16'h9107; mem[1] = 16'h2111; mem[2] = 16'h0000;
    mem[3] = 16'h0000; mem[4] = 16'hC002; mem[5] = 16'hF000;
    mem[6] = 16'hF000; mem[7] = 16'hD008;
    mem[16'h0D] = 16'hE0E0; mem[16'h10] = 16'hDFFC;
    mem[16'h11] = 16'h95F0; mem[16'h12] = 16'h9610;
    mem[16'h13] = 16'h8756; mem[16'h14] = 16'h9804;
    mem[16'h15] = 16'h8958; mem[16'h16] = 16'hF000;
    pf(0); pf(1); pf(2); pf(3); pf(4); pf(7);
    pf(16'h10); pf(16'h0D);
    for (int a = 16'h11; a <= 16'h16; a++) pf(16'(a));
    base = ret_cnt;
    release_rst();
    wait_halt(200, hc);
    chk("br_r14", 32'(dut.rf[14]), 32'h11);
    chk("br_lsr_big", 32'(dut.rf[7]), 32'h0);
    chk("br_lsr4", 32'(dut.rf[9]), 32'h0F);
    chk("br_nzcv", 32'(dut.flags), 32'b0110);
    chk("br_retires", ret_cnt - base, 14);

    // same point with BNE: falls through to PC 5
    do_reset();
    mem[4] = 16'hC102;
    pf(0); pf(1); pf(2); pf(3); pf(4); pf(5);
    base = ret_cnt;
    release_rst();
    wait_halt(100, hc);
    chk("bne_retires", ret_cnt - base, 6);

    // STR/LDR round trip with 4 wait cycles on every access
    do_reset();
    clr_mem();
    delay = 4;
    mem[0] = 16'h9720; mem[1] = 16'h91A5; mem[2] = 16'h9208;
    mem[3] = 16'h7112; mem[4] = 16'h93A5; mem[5] = 16'h5113;
    mem[6] = 16'hB170; mem[7] = 16'hA470; mem[8] = 16'hB471;
    mem[9] = 16'hF000;
    for (int i = 0; i <= 6; i++) pf(16'(i));
    ps(16'h20, 16'hA5A5);
    pf(7);
    pl(16'h20);
    pf(8);
    ps(16'h21, 16'hA5A5);
    pf(9);
    base = ret_cnt;
    release_rst();
    wait_halt(400, hc);
    chk("ls_r4", 32'(dut.rf[4]), 32'hA5A5);
    chk("ls_mem21", 32'(mem[8'h21]), 32'hA5A5);
    chk("ls_retires", ret_cnt - base, 10);

    // reset during a pending fetch, ack pulsed while reset is low
    do_reset();
    load_p1();
    delay = 3;
    release_rst();
    @(negedge clk);
    #3;
    chk("pend_req", 32'(mem_req), 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_drop_req", 32'(mem_req), 0);
    manual = 1'b1;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_hold_pc", 32'(dbg_pc), 0);
    chk("rst_hold_halted", 32'(halted), 0);
    chk("rst_hold_retire", 32'(retire), 0);
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | dut.rf[i];
    chk("rst_regs_zero", 32'(acc), 0);
    chk("rst_flags_zero", 32'(dut.flags), 0);
    mem_ack = 1'b0;
    manual = 1'b0;
    delay = 0;
    pf(0); pf(1); pf(2); pf(3);
    base = ret_cnt;
    release_rst();
    wait_halt(40, hc);
    chk("rerun_r3", 32'(dut.rf[3]), 32'h2);
    chk("rerun_retires", ret_cnt - base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
